// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the operation classifier used by the decode/register-read stage.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;

  typedef enum logic [1:0] {
    OPK_ADD  = 2'd0,
    OPK_ADDI = 2'd1,
    OPK_ILL  = 2'd2
  } op_kind_e;

  function automatic op_kind_e decode_op(input logic [31:0] ins);
    op_kind_e k;
    k = OPK_ILL;
    if (ins[6:0] == OP_REG && ins[14:12] == F3_ADD && ins[31:25] == F7_ADD)
      k = OPK_ADD;
    else if (ins[6:0] == OP_IMM && ins[14:12] == F3_ADD)
      k = OPK_ADDI;
    return k;
  endfunction

endpackage

// File: rtl/regfile.sv
// Architectural register file: two combinational read ports with write-through bypass,
// one synchronous write port, x0 hardwired to zero, synchronous clear.
module regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2
);
  import rv_pkg::*;

  logic [XLEN-1:0] mem [NREG];
  logic            wr_live;

  assign wr_live = we && (waddr != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write wins over the stored entry so the reader never sees stale data.
  always_comb begin
    rdata1 = mem[raddr1];
    if (raddr1 == '0)                      rdata1 = '0;
    else if (wr_live && waddr == raddr1)   rdata1 = wdata;
  end

  always_comb begin
    rdata2 = mem[raddr2];
    if (raddr2 == '0)                      rdata2 = '0;
    else if (wr_live && waddr == raddr2)   rdata2 = wdata;
  end

endmodule

// File: rtl/decode_regread.sv
// Decode / register-read stage: decodes ADD and ADDI, reads operands, and registers
// operands plus control for the ALU one cycle later. Also owns the register-file write port.
module decode_regread #(
  parameter int XLEN  = rv_pkg::XLEN,
  parameter int NREG  = rv_pkg::NREG,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  input  logic [31:0]               instr,
  input  logic                      jump_branch_enable,
  input  logic                      wb_en,
  input  logic [rv_pkg::REG_AW-1:0] wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           src1_value,
  output logic [XLEN-1:0]           src2_value,
  output logic [rv_pkg::REG_AW-1:0] src1_addr,
  output logic [rv_pkg::REG_AW-1:0] src2_addr,
  output logic [XLEN-1:0]           imm,
  output logic [rv_pkg::REG_AW-1:0] rd,
  output logic                      add,
  output logic                      addi,
  output logic                      illegal,
  output logic [CNT_W-1:0]          illegal_count
);
  import rv_pkg::*;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  op_kind_e               kind_p0;
  logic [REG_AW-1:0]      rd_p0;
  logic [REG_AW-1:0]      rs1_p0;
  logic [REG_AW-1:0]      rs2_p0;
  logic signed [11:0]     imm12_p0;
  logic signed [XLEN-1:0] imm_p0;
  logic [XLEN-1:0]        rdata1_p0;
  logic [XLEN-1:0]        rdata2_p0;
  logic                   vld_p0;

  // Stage p0: field extraction, classification and register read (combinational).
  always_comb begin
    kind_p0  = decode_op(instr);
    rd_p0    = instr[11:7];
    rs1_p0   = instr[19:15];
    rs2_p0   = instr[24:20];
    imm12_p0 = instr[31:20];
    imm_p0   = XLEN'(imm12_p0);
    vld_p0   = instr_valid && !jump_branch_enable;
  end

  regfile #(
    .XLEN (XLEN),
    .NREG (NREG),
    .AW   (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (wb_en),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (rs1_p0),
    .rdata1 (rdata1_p0),
    .raddr2 (rs2_p0),
    .rdata2 (rdata2_p0)
  );

  // Stage p1: ALU-facing output register. Bubbles and flushes clear only the
  // control strobes and rd; operand fields keep their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      src1_value    <= '0;
      src2_value    <= '0;
      src1_addr     <= '0;
      src2_addr     <= '0;
      imm           <= '0;
      rd            <= '0;
      add           <= 1'b0;
      addi          <= 1'b0;
      illegal       <= 1'b0;
      illegal_count <= '0;
    end else begin
      add     <= 1'b0;
      addi    <= 1'b0;
      illegal <= 1'b0;
      rd      <= '0;
      if (vld_p0) begin
        case (kind_p0)
          OPK_ADD: begin
            add        <= 1'b1;
            rd         <= rd_p0;
            src1_addr  <= rs1_p0;
            src2_addr  <= rs2_p0;
            src1_value <= rdata1_p0;
            src2_value <= rdata2_p0;
            imm        <= '0;
          end
          OPK_ADDI: begin
            addi       <= 1'b1;
            rd         <= rd_p0;
            src1_addr  <= rs1_p0;
            src2_addr  <= '0;
            src1_value <= rdata1_p0;
            src2_value <= '0;
            imm        <= imm_p0;
          end
          default: begin
            illegal       <= 1'b1;
            illegal_count <= sat_inc(illegal_count);
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_regread.sv
// Scoreboard bench for decode_regread: directed vectors push hand-computed expected
// outputs; a monitor pops one entry per captured edge and compares every output.
module tb_decode_regread;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        jump_branch_enable;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] src1_value, src2_value, imm;
  logic [4:0]  src1_addr, src2_addr, rd;
  logic        add, addi, illegal;
  logic [7:0]  illegal_count;

  decode_regread dut (
    .clk                (clk),
    .reset              (reset),
    .instr_valid        (instr_valid),
    .instr              (instr),
    .jump_branch_enable (jump_branch_enable),
    .wb_en              (wb_en),
    .wb_addr            (wb_addr),
    .wb_data            (wb_data),
    .src1_value         (src1_value),
    .src2_value         (src2_value),
    .src1_addr          (src1_addr),
    .src2_addr          (src2_addr),
    .imm                (imm),
    .rd                 (rd),
    .add                (add),
    .addi               (addi),
    .illegal            (illegal),
    .illegal_count      (illegal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s1v;
    logic [31:0] s2v;
    logic [4:0]  s1a;
    logic [4:0]  s2a;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        add;
    logic        addi;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] I_ADD16  = 32'h00208833; // add  x16,x1,x2
  localparam logic [31:0] I_ADDI19 = 32'hFFF08993; // addi x19,x1,-1
  localparam logic [31:0] I_ADD18  = 32'h00208933; // add  x18,x1,x2
  localparam logic [31:0] I_ADDI5  = 32'h00000293; // addi x5,x0,0
  localparam logic [31:0] I_ADD7   = 32'h000083B3; // add  x7,x1,x0
  localparam logic [31:0] I_SUB    = 32'h40208833; // sub  x16,x1,x2

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("add",           32'(add),           32'(e.add));
      chk("addi",          32'(addi),          32'(e.addi));
      chk("illegal",       32'(illegal),       32'(e.ill));
      chk("illegal_count", 32'(illegal_count), 32'(e.cnt));
      chk("rd",            32'(rd),            32'(e.rd));
      chk("src1_addr",     32'(src1_addr),     32'(e.s1a));
      chk("src2_addr",     32'(src2_addr),     32'(e.s2a));
      chk("src1_value",    src1_value,         e.s1v);
      chk("src2_value",    src2_value,         e.s2v);
      chk("imm",           imm,                e.imm);
    end
  end

  task automatic step(input logic v, input logic [31:0] ins, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic rst_i);
    @(negedge clk);
    reset              = rst_i;
    instr_valid        = v;
    instr              = ins;
    jump_branch_enable = fl;
    wb_en              = we;
    wb_addr            = wa;
    wb_data            = wd;
    @(posedge clk);
    sb.push_back(cur);
  endtask

  task automatic set_bubble();
    cur.add = 1'b0; cur.addi = 1'b0; cur.rd = 5'd0; cur.ill = 1'b0;
  endtask

  task automatic set_add(input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] v1, input logic [31:0] v2);
    cur.add = 1'b1; cur.addi = 1'b0; cur.ill = 1'b0; cur.rd = d;
    cur.s1a = a1; cur.s2a = a2; cur.s1v = v1; cur.s2v = v2; cur.imm = 32'd0;
  endtask

  task automatic set_addi(input logic [4:0] d, input logic [4:0] a1,
                          input logic [31:0] v1, input logic [31:0] im);
    cur.add = 1'b0; cur.addi = 1'b1; cur.ill = 1'b0; cur.rd = d;
    cur.s1a = a1; cur.s2a = 5'd0; cur.s1v = v1; cur.s2v = 32'd0; cur.imm = im;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; instr = '0; jump_branch_enable = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    cur = '{default: '0};

    // reset (with a writeback that must be ignored)
    step(1'b0, 32'd0, 1'b0, 1'b1, 5'd3, 32'd999, 1'b1);
    // write x1=100, x2=50 during bubbles
    set_bubble();
    step(1'b0, 32'd0, 1'b0, 1'b1, 5'd1, 32'd100, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1, 5'd2, 32'd50,  1'b0);
    // ADD x16,x1,x2
    set_add(5'd16, 5'd1, 5'd2, 32'd100, 32'd50);
    step(1'b1, I_ADD16, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    // ADDI x19,x1,-1
    set_addi(5'd19, 5'd1, 32'd100, 32'hFFFFFFFF);
    step(1'b1, I_ADDI19, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    // ADD x18,x1,x2 with same-cycle write x1=80 (bypass)
    set_add(5'd18, 5'd1, 5'd2, 32'd80, 32'd50);
    step(1'b1, I_ADD18, 1'b0, 1'b1, 5'd1, 32'd80, 1'b0);
    // write to x0 dropped, ADDI x5,x0,0
    set_addi(5'd5, 5'd0, 32'd0, 32'd0);
    step(1'b1, I_ADDI5, 1'b0, 1'b1, 5'd0, 32'h0000DEAD, 1'b0);
    // ADD x7,x1,x0: x1 holds 80, x0 still 0
    set_add(5'd7, 5'd1, 5'd0, 32'd80, 32'd0);
    step(1'b1, I_ADD7, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    // three SUBs -> illegal pulses, count 1..3, operand fields hold
    for (int i = 1; i <= 3; i++) begin
      set_bubble(); cur.ill = 1'b1; cur.cnt = 8'(i);
      step(1'b1, I_SUB, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    end
    set_bubble();
    step(1'b0, I_SUB, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    // flushed ADD and flushed SUB: no strobes, no count
    step(1'b1, I_ADD16, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    step(1'b1, I_SUB,   1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
    // ADDI right after flush
    set_addi(5'd19, 5'd1, 32'd80, 32'hFFFFFFFF);
    step(1'b1, I_ADDI19, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    // saturation of the illegal counter at 255
    set_bubble(); cur.ill = 1'b1;
    for (int i = 0; i < 255; i++) begin
      cur.cnt = (3 + i + 1 > 255) ? 8'd255 : 8'(3 + i + 1);
      step(1'b1, I_SUB, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    end
    // mid-stream reset with a valid ADD and a writeback, both discarded
    cur = '{default: '0};
    step(1'b1, I_ADD16, 1'b0, 1'b1, 5'd2, 32'd77, 1'b1);
    // x1 and x2 now read 0
    set_addi(5'd19, 5'd1, 32'd0, 32'hFFFFFFFF);
    step(1'b1, I_ADDI19, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    set_add(5'd16, 5'd1, 5'd2, 32'd0, 32'd0);
    step(1'b1, I_ADD16, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    @(negedge clk);
    instr_valid = 1'b0; wb_en = 1'b0;
    repeat (4) begin
      if (sb.size() != 0) @(negedge clk);
    end
    @(posedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/decode_regread.md
Name: decode_regread

Overview:
- Decode / register-read stage directly upstream of the ALU stage.
- Accepts one 32-bit RV32I instruction per cycle from fetch and decodes ADD and ADDI. Reads the 32x32 architectural register file and presents registered operands and control to the ALU.
- Also owns the register-file write port, fed by the ALU outputs alu_done, write_addr and result.

Parameters:
- XLEN, 32, data/register width.
- NREG, 32, number of architectural registers (addr width = 5).
- CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  fetch presents a valid instruction this cycle.
- instr  in  32  instruction word.
- jump_branch_enable  in  1  flush: the instruction registered at this edge is dropped.
- wb_en  in  1  writeback strobe (from ALU alu_done).
- wb_addr  in  5  writeback register (from ALU write_addr).
- wb_data  in  XLEN  writeback data (from ALU result).
- src1_value  out  XLEN  rs1 operand to ALU.
- src2_value  out  XLEN  rs2 operand to ALU (0 for ADDI).
- src1_addr  out  5  rs1 index to ALU (for its forwarding).
- src2_addr  out  5  rs2 index (0 for ADDI).
- imm  out  XLEN  sign-extended I-immediate (0 for ADD).
- rd  out  5  destination register.
- add  out  1  ALU performs src1+src2.
- addi  out  1  ALU performs src1+imm.
- illegal  out  1  one-cycle pulse: unsupported instruction decoded.
- illegal_count  out  CNT_W  saturating count of illegal instructions.

Behaviour:
- All ALU-facing outputs are registered. Latency is exactly 1 cycle from instr_valid to add/addi.
- Reset (sync, high):
  - At the edge: all outputs go to 0, illegal_count goes to 0, all registers x0..x31 go to 0.
  - A writeback in the same cycle as reset is ignored.
  - Reset mid-stream discards the instruction being registered.
- Decode:
  - ADD: opcode 0110011, funct3 000, funct7 0000000.
  - ADDI: opcode 0010011, funct3 000.
  - Field extraction: rd = instr[11:7], rs1 = instr[19:15], rs2 = instr[24:20].
  - ADDI immediate: sign-extend instr[31:20] to XLEN.
  - ADD: imm = 0.
  - ADDI: src2_addr = 0 and src2_value = 0.
- Bubble (instr_valid=0): add=addi=0, rd=0, illegal=0. Other outputs hold their previous values.
- Illegal (valid, not ADD/ADDI):
  - add=addi=0 and rd=0; illegal=1 for one cycle.
  - illegal_count increments, saturating at 2^CNT_W-1.
- Flush (jump_branch_enable=1) at an edge:
  - Same outputs as a bubble.
  - Flush overrides illegal: no pulse and no count.
- Register file:
  - Write at the edge when wb_en=1 and wb_addr!=0. Writes to x0 are dropped; x0 always reads 0.
  - Reads are combinational on rs1/rs2 and are captured into src*_value.
  - Write-through bypass: if wb_en=1, wb_addr!=0 and wb_addr equals rs, the captured value is wb_data, not the stale entry.
- Writeback is independent of instr_valid and flush; it happens during bubbles, flushes and illegal cycles.
- No stall or back-pressure: one instruction is accepted every cycle. RAW hazards against the instruction in the ALU are resolved by the ALU using src*_addr.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants OP_REG=7'b0110011 and OP_IMM=7'b0010011;
  - F3_ADD=3'b000 and F7_ADD=7'b0000000;
  - XLEN and the register address width.
- One sub-module, regfile: 2 async read ports, 1 sync write port, x0 hardwired, sync active-high clear, bypass logic inside.
- Decode and the output register stay in decode_regread.

Test Plan:
- Reset, then write x1=100 and x2=50 via wb. Issue ADD x16,x1,x2 (0x00208833) -> next cycle: add=1, rd=16, src1_value=100, src2_value=50, imm=0.
- Issue ADDI x19,x1,-1 (0xFFF08993) -> addi=1, rd=19, imm=0xFFFFFFFF, src2_addr=0, src2_value=0.
- Same-cycle wb_en=1, wb_addr=1, wb_data=80 while decoding ADD x18,x1,x2 -> src1_value=80 (bypass). x1 reads 80 on later instructions.
- wb_addr=0, wb_data=0xDEAD, then ADDI x5,x0,0 -> src1_value=0; x0 unchanged.
- Issue SUB (0x40208833) three times -> illegal pulses each cycle, illegal_count=3, add=addi=0.
- Issue ADD with jump_branch_enable=1 -> add=0, rd=0. Next cycle (valid ADDI, no flush) -> addi=1.
- Assert reset for 1 cycle mid-stream -> all outputs and illegal_count go to 0. x1 then reads 0.
